wheel_steering_controller: RTL and testbench
============================================

Name: wheel_steering_controller

Overview:
- Sequences the quadrature wheel interface (interface_wheel) for Cyclone Cruiser and turns its raw 8-bit count into a centred, saturated steering position and a 3-lane selection for the game logic.
- Owns the interface's clear line: it issues a calibration clear on start and on recentre requests.
- Tracks count deltas, rejects glitch jumps, emits lane-change pulses and flags wheel inactivity.

Parameters:
- CLR_CYCLES, 4, cycles enc_clear is held high during calibration (1..15)
- POS_MAX, 64, saturation magnitude of position (1..127)
- LANE_TH, 16, |position| threshold separating centre lane from side lanes (< POS_MAX)
- MAX_STEP, 8, largest |delta| per sample accepted as real motion
- IDLE_CYCLES, 50000000, motionless cycles in TRACK before idle asserts (1 s at 50 MHz)
- TIMER_W, 26, idle counter width; must satisfy 2^TIMER_W > IDLE_CYCLES

Ports:
- clk  in  1  system clock, 50 MHz
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse: calibrate/recentre
- stop  in  1  one-cycle pulse: return to IDLE
- enc_count  in  8  count from interface_wheel
- enc_clear  out  1  active-high clear to interface_wheel reset input
- ready  out  1  high while in TRACK
- position  out  8  signed two's-complement steering position
- lane  out  2  0 = left, 1 = centre, 2 = right
- turn_left  out  1  one-cycle pulse when lane decreases
- turn_right  out  1  one-cycle pulse when lane increases
- idle  out  1  level: no motion for IDLE_CYCLES
- glitch  out  1  one-cycle pulse when a sample is rejected

Behaviour:
- Reset (reset = 0, asynchronous): state IDLE, enc_clear 0, ready 0, position 0, lane 1, all pulses 0, idle 0, prev_count 0, timers 0.
- FSM states: IDLE, CLEAR, SETTLE, TRACK. All outputs are registered.
- IDLE:
  - start goes to CLEAR next cycle.
  - Outputs hold their reset values. position and lane are forced to 0 and 1 on entry.
- CLEAR:
  - enc_clear = 1 for exactly CLR_CYCLES cycles, then go to SETTLE.
  - position is forced to 0, lane to 1, idle to 0. No turn pulses are emitted.
- SETTLE (1 cycle):
  - enc_clear = 0.
  - prev_count <= enc_count, which must read 0 after the clear.
  - Go to TRACK.
- TRACK:
  - ready = 1.
  - Each cycle compute delta = enc_count - prev_count mod 256, interpreted as signed 8-bit.
  - prev_count <= enc_count every cycle, including rejected samples.
  - |delta| > MAX_STEP: position unchanged, glitch pulses for 1 cycle. The sample counts as no motion for the idle timer.
  - Otherwise position <= sat(position + delta, -POS_MAX, +POS_MAX). Compute the sum in 9+ bits before clamping.
- Counter wrap: 8'hFF to 8'h00 yields delta = +1; 8'h00 to 8'hFF yields delta = -1. Never a glitch.
- Lane decode from the registered position, with lane updating 1 cycle after position:
  - position < -LANE_TH gives lane 0.
  - position > +LANE_TH gives lane 2.
  - Otherwise lane 1, with boundaries inclusive to centre.
- Lane pulses:
  - turn_left pulses in the same cycle lane decreases; turn_right in the same cycle it increases.
  - A 0 to 2 jump gives a single turn_right pulse, not two.
- Idle timer:
  - Clears on any accepted nonzero delta; otherwise increments, saturating.
  - idle = 1 when the timer reaches IDLE_CYCLES, and stays high until the next accepted motion. It drops the cycle after that motion.
- Start in TRACK (recentre): go to CLEAR and reassert the full clear sequence.
- Start while already in CLEAR or SETTLE: ignored.
- stop in any state: go to IDLE next cycle and deassert enc_clear immediately.
- start and stop in the same cycle: stop wins.
- Reset asserted mid-operation: everything returns to reset values asynchronously, including enc_clear dropping to 0.

Decomposition:
- Shared package (wheel_pkg):
  - State encoding constants: IDLE = 2'd0, CLEAR = 2'd1, SETTLE = 2'd2, TRACK = 2'd3.
  - Lane codes: LANE_LEFT, LANE_CENTRE, LANE_RIGHT.
  - Default POS_MAX, LANE_TH and MAX_STEP, so the game logic uses the same lane codes.
- One natural sub-module, wheel_delta_sat:
  - Combinational signed delta, glitch check and saturating add.
  - Inputs prev_count, enc_count, position; outputs next_position, accepted, is_motion.
- The FSM, lane decode and idle timer stay in the top.

Test Plan:
- Reset then start: enc_clear high for exactly 4 cycles, SETTLE, ready = 1 on cycle 6 after start; position = 0, lane = 1.
- enc_count stepped 0 to 17 in +1 steps: position = 17; lane goes 1 to 2 on the cycle after position = 17; single turn_right pulse. Stepping back to 16 gives lane 1 and one turn_left pulse.
- enc_count 0 to 12 in one cycle: glitch pulse, position stays 0. Next sample 12 to 13 gives position = 1.
- Counting 0x00 to 0xFF, then decrementing through 0xC0 (-64 total) and 10 more: position saturates at -64, lane = 0; wrap produces no glitch.
- IDLE_CYCLES = 20 with enc_count constant: idle asserts at 20 motionless cycles. One +1 step clears idle the next cycle.
- start mid-TRACK at position = 30: enc_clear reasserts, position forced to 0, lane = 1. A start and stop in the same cycle gives IDLE with ready = 0. A reset pulse mid-CLEAR drops enc_clear asynchronously.

Source files
------------

// File: rtl/wheel_pkg.sv
// Shared definitions for the steering wheel front end: FSM states, lane codes
// and default geometry so the game logic decodes lanes identically.
package wheel_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CLEAR  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_TRACK  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    LANE_LEFT   = 2'd0,
    LANE_CENTRE = 2'd1,
    LANE_RIGHT  = 2'd2
  } lane_t;

  localparam int DEF_POS_MAX  = 64;
  localparam int DEF_LANE_TH  = 16;
  localparam int DEF_MAX_STEP = 8;

  // Threshold values themselves belong to the centre lane.
  function automatic logic [1:0] lane_of(input logic signed [7:0] pos,
                                         input logic signed [7:0] th);
    if (pos < -th)     return LANE_LEFT;
    else if (pos > th) return LANE_RIGHT;
    else               return LANE_CENTRE;
  endfunction

endpackage

// File: rtl/wheel_delta_sat.sv
// Signed count delta, glitch rejection and saturating position update.
module wheel_delta_sat
  import wheel_pkg::*;
#(
  parameter int POS_MAX  = DEF_POS_MAX,
  parameter int MAX_STEP = DEF_MAX_STEP
) (
  input  logic [7:0]        prev_count,
  input  logic [7:0]        enc_count,
  input  logic signed [7:0] position,
  output logic signed [7:0] next_position,
  output logic              accepted,
  output logic              is_motion
);

  localparam logic signed [9:0] L_POS_MAX  = 10'(POS_MAX);
  localparam logic signed [9:0] L_MAX_STEP = 10'(MAX_STEP);

  logic signed [7:0] w_delta;
  logic signed [9:0] w_delta_ext;
  logic signed [9:0] w_sum;

  // NOTE: every signal written in an always_comb gets a default at the top,
  // otherwise a missed branch infers a latch.
  always_comb begin
    w_delta       = signed'(enc_count - prev_count);
    w_delta_ext   = {{2{w_delta[7]}}, w_delta};
    w_sum         = {{2{position[7]}}, position} + w_delta_ext;
    accepted      = (w_delta_ext <= L_MAX_STEP) && (w_delta_ext >= -L_MAX_STEP);
    is_motion     = accepted && (w_delta != 8'sd0);
    next_position = position;
    if (accepted) begin
      if (w_sum > L_POS_MAX)       next_position = L_POS_MAX[7:0];
      else if (w_sum < -L_POS_MAX) next_position = 8'(-L_POS_MAX);
      else                         next_position = w_sum[7:0];
    end
  end

endmodule

// File: rtl/wheel_steering_controller.sv
// Calibrates the quadrature wheel interface and converts its raw count into a
// saturated steering position, lane selection, turn pulses and idle flag.
module wheel_steering_controller
  import wheel_pkg::*;
#(
  parameter int CLR_CYCLES  = 4,
  parameter int POS_MAX     = DEF_POS_MAX,
  parameter int LANE_TH     = DEF_LANE_TH,
  parameter int MAX_STEP    = DEF_MAX_STEP,
  parameter int IDLE_CYCLES = 50000000,
  parameter int TIMER_W     = 26
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [7:0]        enc_count,
  output logic              enc_clear,
  output logic              ready,
  output logic signed [7:0] position,
  output logic [1:0]        lane,
  output logic              turn_left,
  output logic              turn_right,
  output logic              idle,
  output logic              glitch
);

  localparam logic [3:0]         L_CLR_LAST = 4'(CLR_CYCLES - 1);
  localparam logic [TIMER_W-1:0] L_IDLE     = TIMER_W'(IDLE_CYCLES);
  localparam logic signed [7:0]  L_LANE_TH  = 8'(LANE_TH);

  state_t             r_state;
  logic [3:0]         r_clr_cnt;
  logic [7:0]         r_prev;
  logic [TIMER_W-1:0] r_timer;

  logic signed [7:0]  w_next_pos;
  logic               w_accepted;
  logic               w_motion;
  logic [1:0]         w_lane;
  logic [TIMER_W-1:0] w_timer_nxt;
  logic               w_calibrate;

  wheel_delta_sat #(.POS_MAX(POS_MAX), .MAX_STEP(MAX_STEP)) u_delta (
    .prev_count   (r_prev),
    .enc_count    (enc_count),
    .position     (position),
    .next_position(w_next_pos),
    .accepted     (w_accepted),
    .is_motion    (w_motion)
  );

  // Recentre is only honoured from IDLE or TRACK; mid-calibration starts drop.
  assign w_calibrate = start && (r_state == ST_IDLE || r_state == ST_TRACK);
  assign w_lane      = lane_of(position, L_LANE_TH);
  assign w_timer_nxt = w_motion          ? '0 :
                       (r_timer == L_IDLE) ? r_timer : r_timer + TIMER_W'(1);

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_clr_cnt  <= '0;
      r_prev     <= '0;
      r_timer    <= '0;
      enc_clear  <= 1'b0;
      ready      <= 1'b0;
      position   <= '0;
      lane       <= LANE_CENTRE;
      turn_left  <= 1'b0;
      turn_right <= 1'b0;
      idle       <= 1'b0;
      glitch     <= 1'b0;
    end else if (stop || w_calibrate) begin
      r_state    <= stop ? ST_IDLE : ST_CLEAR;
      enc_clear  <= !stop;
      r_clr_cnt  <= '0;
      r_prev     <= '0;
      r_timer    <= '0;
      ready      <= 1'b0;
      position   <= '0;
      lane       <= LANE_CENTRE;
      turn_left  <= 1'b0;
      turn_right <= 1'b0;
      idle       <= 1'b0;
      glitch     <= 1'b0;
    end else begin
      turn_left  <= 1'b0;
      turn_right <= 1'b0;
      glitch     <= 1'b0;
      case (r_state)
        ST_CLEAR: begin
          if (r_clr_cnt == L_CLR_LAST) begin
            r_state   <= ST_SETTLE;
            enc_clear <= 1'b0;
          end else begin
            r_clr_cnt <= r_clr_cnt + 4'd1;
          end
        end
        ST_SETTLE: begin
          r_prev  <= enc_count;
          r_timer <= '0;
          ready   <= 1'b1;
          r_state <= ST_TRACK;
        end
        ST_TRACK: begin
          r_prev     <= enc_count;
          position   <= w_next_pos;
          glitch     <= !w_accepted;
          lane       <= w_lane;
          turn_left  <= (w_lane < lane);
          turn_right <= (w_lane > lane);
          r_timer    <= w_timer_nxt;
          idle       <= (w_timer_nxt == L_IDLE);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wheel_steering_controller.sv
// Self-checking bench: directed scenarios plus randomized wheel motion, all
// compared every cycle against a cycle-count based behavioural model.
module tb_wheel_steering_controller;

  localparam int CLR      = 4;
  localparam int PMAX     = 64;
  localparam int LTH      = 16;
  localparam int MSTEP    = 8;
  localparam int IDLE_CYC = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] enc = 8'd0;
  logic       enc_clear, ready, turn_left, turn_right, idle, glitch;
  logic [7:0] position;
  logic [1:0] lane;

  int total = 0;
  int bad = 0;
  int n_left, n_right, n_glitch;

  always #5 clk = ~clk;

  wheel_steering_controller #(
    .CLR_CYCLES(CLR), .POS_MAX(PMAX), .LANE_TH(LTH), .MAX_STEP(MSTEP),
    .IDLE_CYCLES(IDLE_CYC), .TIMER_W(5)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .enc_count(enc),
    .enc_clear(enc_clear), .ready(ready), .position(position), .lane(lane),
    .turn_left(turn_left), .turn_right(turn_right), .idle(idle), .glitch(glitch)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: m_k counts cycles since the accepted start (capped at CLR+1 once tracking).
  bit m_active = 0;
  int m_k = 0;
  int m_pos = 0, m_lane = 1, m_prev = 0, m_timer = 0;
  bit m_clear = 0, m_ready = 0, m_tl = 0, m_tr = 0, m_idle = 0, m_glitch = 0;

  function automatic int decode(input int p);
    if (p < -LTH) return 0;
    if (p > LTH)  return 2;
    return 1;
  endfunction

  task automatic model_reset();
    m_active = 0; m_k = 0; m_pos = 0; m_lane = 1; m_prev = 0; m_timer = 0;
    m_clear = 0; m_ready = 0; m_tl = 0; m_tr = 0; m_idle = 0; m_glitch = 0;
  endtask

  task automatic model_track(input int e);
    int d, nl;
    bit motion;
    nl = decode(m_pos);
    d = ((e - m_prev) % 256 + 256) % 256;
    if (d >= 128) d -= 256;
    m_prev = e;
    motion = 0;
    if (d > MSTEP || d < -MSTEP) m_glitch = 1;
    else begin
      m_pos = m_pos + d;
      if (m_pos > PMAX)  m_pos = PMAX;
      if (m_pos < -PMAX) m_pos = -PMAX;
      motion = (d != 0);
    end
    m_tl = (nl < m_lane);
    m_tr = (nl > m_lane);
    m_lane = nl;
    m_timer = motion ? 0 : ((m_timer < IDLE_CYC) ? m_timer + 1 : IDLE_CYC);
    m_idle = (m_timer >= IDLE_CYC);
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) model_reset();
    else if (stop) model_reset();
    else if (start && (!m_active || m_k > CLR)) begin
      model_reset();
      m_active = 1;
      m_clear = 1;
    end else if (m_active) begin
      m_tl = 0; m_tr = 0; m_glitch = 0;
      if (m_k == CLR) begin
        m_prev = int'(enc); m_k = CLR + 1; m_ready = 1; m_timer = 0;
      end else if (m_k > CLR) model_track(int'(enc));
      else begin
        m_k++;
        m_clear = (m_k < CLR);
      end
    end
  end

  always @(negedge clk) begin
    check("enc_clear", 32'(enc_clear), 32'(m_clear));
    check("ready", 32'(ready), 32'(m_ready));
    check("position", 32'(position), 32'(m_pos & 255));
    check("lane", 32'(lane), 32'(m_lane));
    check("turn_left", 32'(turn_left), 32'(m_tl));
    check("turn_right", 32'(turn_right), 32'(m_tr));
    check("idle", 32'(idle), 32'(m_idle));
    check("glitch", 32'(glitch), 32'(m_glitch));
  end

  task automatic step_enc(input logic [7:0] v);
    enc = v;
    @(negedge clk);
    if (turn_left)  n_left++;
    if (turn_right) n_right++;
    if (glitch)     n_glitch++;
  endtask

  task automatic calibrate();
    enc = 8'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (CLR + 1) @(negedge clk);
  endtask

  int clr_len, first_ready, dir, hold;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_pos", 32'(position), 32'd0);
    check("rst_lane", 32'(lane), 32'd1);
    check("rst_clear", 32'(enc_clear), 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Calibration timing
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    clr_len = 0; first_ready = -1;
    for (int i = 0; i < 10; i++) begin
      if (enc_clear) clr_len++;
      if (ready && first_ready < 0) first_ready = i + 1;
      if (i < 9) @(negedge clk);
    end
    check("clr_len", 32'(clr_len), 32'd4);
    check("ready_cycle", 32'(first_ready), 32'd6);

    // Right lane crossing and back
    n_left = 0; n_right = 0;
    for (int v = 1; v <= 17; v++) step_enc(8'(v));
    check("pos17", 32'(position), 32'd17);
    check("lane_lag", 32'(lane), 32'd1);
    step_enc(8'd17);
    check("lane_right", 32'(lane), 32'd2);
    step_enc(8'd16);
    step_enc(8'd16);
    check("lane_back", 32'(lane), 32'd1);
    check("n_right", 32'(n_right), 32'd1);
    check("n_left", 32'(n_left), 32'd1);

    // Glitch rejection
    calibrate();
    step_enc(8'd12);
    check("glitch_pulse", 32'(glitch), 32'd1);
    check("glitch_pos", 32'(position), 32'd0);
    step_enc(8'd13);
    check("after_glitch", 32'(position), 32'd1);

    // Wrap and negative saturation
    calibrate();
    n_glitch = 0;
    step_enc(8'hFF);
    check("wrap_pos", 32'(position), 32'hFF);
    for (int v = 8'hFE; v >= 8'hB6; v--) step_enc(8'(v));
    step_enc(8'hB6);
    check("sat_pos", 32'(position), 32'hC0);
    check("sat_lane", 32'(lane), 32'd0);
    check("wrap_glitches", 32'(n_glitch), 32'd0);

    // Idle timer
    repeat (24) step_enc(8'hB6);
    check("idle_on", 32'(idle), 32'd1);
    step_enc(8'hB7);
    check("idle_drop", 32'(idle), 32'd0);
    check("idle_pos", 32'(position), 32'hC1);
    repeat (19) step_enc(8'hB7);
    check("idle_19", 32'(idle), 32'd0);
    step_enc(8'hB7);
    check("idle_20", 32'(idle), 32'd1);

    // Recentre from position 30
    calibrate();
    for (int v = 1; v <= 30; v++) step_enc(8'(v));
    check("pos30", 32'(position), 32'd30);
    enc = 8'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("recentre_clear", 32'(enc_clear), 32'd1);
    check("recentre_pos", 32'(position), 32'd0);
    check("recentre_lane", 32'(lane), 32'd1);

    // start and stop together: stop wins
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    check("stopwin_ready", 32'(ready), 32'd0);
    check("stopwin_clear", 32'(enc_clear), 32'd0);
    repeat (3) @(negedge clk);
    check("stay_idle", 32'(enc_clear), 32'd0);

    // Asynchronous reset during CLEAR
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 reset = 1'b0;
    #1 check("async_clear", 32'(enc_clear), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Randomized motion with occasional recentre, stop and glitch jumps
    calibrate();
    dir = 1; hold = 0;
    for (int c = 0; c < 3000; c++) begin
      int r, sel;
      r = $urandom_range(0, 999);
      start = (r < 8);
      stop  = (r >= 995) || (r == 0);
      sel = $urandom_range(0, 31);
      if ($urandom_range(0, 63) == 0) dir = -dir;
      if (hold > 0) hold--;
      else if (sel == 0) enc = enc + 8'($urandom_range(9, 247));
      else if (sel == 1) enc = enc + 8'(MSTEP * dir);
      else if (sel == 2) enc = enc + 8'((MSTEP + 1) * dir);
      else if (sel == 3) hold = 25;
      else if (sel < 8) ;
      else enc = enc + 8'(dir * $urandom_range(0, 3) - ($urandom_range(0, 3) == 0 ? dir : 0));
      if (start) enc = 8'd0;
      @(negedge clk);
    end
    start = 1'b0; stop = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
